spi_master_gen: RTL and testbench
=================================

Name: spi_master_gen

Overview:
- Parametrised, full-duplex SPI master; next generation of the team's fixed 8-bit single-slave SPI master.
- Adds configurable word width, clock divider and chip-select count, all four CPOL/CPHA modes, selectable bit order, received-data capture and a start/busy/done handshake.
- Sits between an on-chip controller (register block or FSM) and external SPI slaves on the Spartan-6 board.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 4, clk cycles per spi_clk half-period (>=1)
NUM_CS, 2, number of chip-select lines (>=1)
CS_W, max(1,clog2(NUM_CS)), width of cs_sel (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  transfer request, sampled only in IDLE
cs_sel  input  CS_W  slave index for the request
polarity  input  1  CPOL
phase  input  1  CPHA
lsb_first  input  1  1 = LSB shifted first, 0 = MSB first
data_wr  input  DATA_WIDTH  transmit word
data_rd  output  DATA_WIDTH  last received word
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle completion pulse
spi_clk  output  1  serial clock
cs  output  NUM_CS  active-low chip selects
mosi  output  1  serial data out
miso  input  1  serial data in
state  output  2  FSM state (debug): IDLE=0, LEAD=1, XFER=2, LAG=3
count  output  clog2(DATA_WIDTH+1)  bits completed in current transfer (debug)

Behaviour:
- Reset (reset low, async): state=IDLE, busy=0, done=0, cs=all 1, spi_clk=0, mosi=0, data_rd=0, count=0, divider=0. Takes effect immediately, including mid-transfer. No done is issued for an aborted transfer.
- IDLE:
  - spi_clk = registered polarity (one-cycle lag).
  - mosi=0.
  - start=1 with cs_sel<NUM_CS: capture data_wr, cs_sel, polarity, phase and lsb_first; go to LEAD.
  - start with cs_sel>=NUM_CS: ignored, no busy, no done.
  - Input changes after capture have no effect until the next transfer.
- busy is high in LEAD/XFER/LAG for exactly (2*DATA_WIDTH+2)*CLK_DIV cycles. done pulses in the first IDLE cycle after busy falls.
- Divider counts 0..CLK_DIV-1; a tick occurs at CLK_DIV-1, then the divider wraps to 0. Each of LEAD, each XFER half-period, and LAG lasts one tick.
- LEAD: cs[sel]=0, other cs stay 1. If CPHA=0, mosi = first bit on LEAD entry. On tick, go to XFER.
- XFER: spi_clk toggles on each tick, giving 2*DATA_WIDTH edges. Odd edges are leading, even edges trailing.
  - CPHA=0: sample miso on leading edges; update mosi on trailing edges, except after the last bit.
  - CPHA=1: update mosi on leading edges (first bit on the first leading edge); sample miso on trailing edges.
  - count increments at each sample edge. After edge 2*DATA_WIDTH, spi_clk equals CPOL; go to LAG.
- LAG: cs held low for one tick. Then cs=all 1, data_rd <= receive shift register, go to IDLE with done=1.
- Bit order: lsb_first applies to both tx and rx. A mosi->miso loopback always yields data_rd == data_wr.
- start while busy: ignored.
- start in the done cycle: accepted, giving a back-to-back transfer. cs is deasserted for at least one clk between transfers.
- data_rd is stable except on completion. All outputs are registered.

Test Plan:
1. Mode 0, DATA_WIDTH=8, CLK_DIV=4, data_wr=0xAB, cs_sel=0, MSB first, mosi looped to miso -> cs[0] low and cs[1] high; mosi 1,0,1,0,1,0,1,1 valid at each of 8 rising spi_clk edges; busy high 72 cycles; done one pulse; data_rd=0xAB.
2. Slave model in modes 1, 2, 3 returning 0x5C, data_wr=0x3A -> slave receives 0x3A and data_rd=0x5C in each mode. Idle spi_clk equals CPOL; exactly 8 sample edges of the correct polarity.
3. lsb_first=1, data_wr=0x01, mode 0 -> first mosi bit 1 then seven 0s; slave sending 0x80 LSB-first gives data_rd=0x80.
4. Transfer to cs_sel=0, start held high in the done cycle with cs_sel=1 -> second transfer begins immediately; cs[0] high at least 1 cycle before cs[1] falls; two done pulses.
5. reset low during XFER after count=3 -> same cycle: cs=all 1, busy=0, spi_clk=0, no done, data_rd unchanged at 0. After release, a fresh 0xC3 loopback gives data_rd=0xC3.
6. start with cs_sel=2 (NUM_CS=2) -> no busy, cs stays all 1. start pulsed mid-transfer -> ignored; exactly one done.

Source files
------------

// File: rtl/spi_master_gen.sv
// spi_master_gen: parametrised full-duplex SPI master with all four CPOL/CPHA modes and NUM_CS active-low selects.
// Latency: busy for (2*DATA_WIDTH+2)*CLK_DIV cycles after start is taken; done pulses in the first idle cycle after that.
// Backpressure: start is taken only in IDLE with a valid cs_sel; requests while busy or out of range are dropped, not queued.
// Ports: clk/reset (async, active low); start, cs_sel, polarity, phase, lsb_first, data_wr (request);
//        data_rd, busy, done (result); spi_clk, cs, mosi, miso (SPI pins); state, count (debug).
module spi_master_gen #(
  parameter  int DATA_WIDTH = 8,
  parameter  int CLK_DIV    = 4,
  parameter  int NUM_CS     = 2,
  localparam int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic                  polarity,
  input  logic                  phase,
  input  logic                  lsb_first,
  input  logic [DATA_WIDTH-1:0] data_wr,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_clk,
  output logic [NUM_CS-1:0]     cs,
  output logic                  mosi,
  input  logic                  miso,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      count
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LEAD = 2'd1, XFER = 2'd2, LAG = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  spi_clk_q, spi_clk_d;
  logic [NUM_CS-1:0]     cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;

  logic                  tick, lead_edge, sample_edge, last_edge;
  logic [DIV_W-1:0]      div_step;
  logic [(2**CS_W)-1:0]  sel_ok;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  // Table of legal selects; avoids a compare that is constant when NUM_CS is a power of two.
  always_comb begin
    sel_ok = '0;
    for (int i = 0; i < 2**CS_W; i++) sel_ok[i] = (i < NUM_CS);
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    count_d   = count_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    spi_clk_d = spi_clk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    data_rd_d = data_rd_q;

    tick        = (div_q == DIV_W'(CLK_DIV - 1));
    div_step    = tick ? '0 : div_q + DIV_W'(1);
    // The edge about to happen is edge_q+1; odd-numbered edges are leading.
    lead_edge   = ~edge_q[0];
    sample_edge = (lead_edge != cpha_q);
    last_edge   = (edge_q == EDGE_W'(2 * DATA_WIDTH - 1));

    case (state_q)
      IDLE: begin
        div_d     = '0;
        spi_clk_d = polarity;
        mosi_d    = 1'b0;
        cs_d      = '1;
        if (start && sel_ok[cs_sel]) begin
          state_d = LEAD;
          busy_d  = 1'b1;
          cs_d    = ~(NUM_CS'(1) << cs_sel);
          cpha_d  = phase;
          lsb_d   = lsb_first;
          edge_d  = '0;
          count_d = '0;
          // CPHA=0 slaves sample on the first edge, so the first bit goes out with cs.
          if (!phase) begin
            mosi_d = first_bit(data_wr, lsb_first);
            tx_d   = shift_out(data_wr, lsb_first);
          end else begin
            tx_d   = data_wr;
          end
        end
      end
      LEAD: begin
        div_d = div_step;
        if (tick) state_d = XFER;
      end
      XFER: begin
        div_d = div_step;
        if (tick) begin
          spi_clk_d = ~spi_clk_q;
          edge_d    = edge_q + EDGE_W'(1);
          if (sample_edge) begin
            rx_d    = lsb_q ? {miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso};
            count_d = count_q + CNT_W'(1);
          end else if (cpha_q || !last_edge) begin
            // CPHA=0 final trailing edge has no bit left to present.
            mosi_d = first_bit(tx_q, lsb_q);
            tx_d   = shift_out(tx_q, lsb_q);
          end
          if (last_edge) state_d = LAG;
        end
      end
      LAG: begin
        div_d = div_step;
        if (tick) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cs_d      = '1;
          mosi_d    = 1'b0;
          data_rd_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      count_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      spi_clk_q <= 1'b0;
      cs_q      <= '1;
      mosi_q    <= 1'b0;
      data_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      count_q   <= count_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      spi_clk_q <= spi_clk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      data_rd_q <= data_rd_d;
    end
  end

  assign data_rd = data_rd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign spi_clk = spi_clk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;
  assign state   = state_q;
  assign count   = count_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// tb_spi_master_gen: scoreboard bench for spi_master_gen with a mode-aware SPI slave model.
// Three chip selects are used so that an out-of-range cs_sel value is representable.
// Expected words/selects are queued at stimulus time and popped by the done and slave monitors.
module tb_spi_master_gen;
  localparam int DW       = 8;
  localparam int DIV      = 4;
  localparam int NCS      = 3;
  localparam int CSW      = 2;
  localparam int CNTW     = 4;
  localparam int BUSY_CYC = (2 * DW + 2) * DIV;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [CSW-1:0]  cs_sel = '0;
  logic            polarity = 1'b0;
  logic            phase = 1'b0;
  logic            lsb_first = 1'b0;
  logic [DW-1:0]   data_wr = '0;
  logic [DW-1:0]   data_rd;
  logic            busy, done, spi_clk, mosi, miso;
  logic [NCS-1:0]  cs;
  logic [1:0]      state;
  logic [CNTW-1:0] count;

  logic            loop_en = 1'b1;
  logic            miso_s = 1'b0;
  assign miso = loop_en ? mosi : miso_s;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  exp_rd_q[$];
  logic [DW-1:0]  exp_sl_q[$];
  logic [NCS-1:0] exp_cs_q[$];

  // Slave configuration and state
  logic           s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
  logic [DW-1:0]  s_word = '0;
  logic [DW-1:0]  s_rx = '0;
  logic           s_active = 1'b0;
  logic           s_lead;
  int             s_edges = 0, s_bit = 0;
  logic [NCS-1:0] prev_cs = '1;
  logic           prev_sclk = 1'b0;
  int             busy_cnt = 0;

  spi_master_gen #(.DATA_WIDTH(DW), .CLK_DIV(DIV), .NUM_CS(NCS)) dut (
    .clk(clk), .reset(reset), .start(start), .cs_sel(cs_sel), .polarity(polarity),
    .phase(phase), .lsb_first(lsb_first), .data_wr(data_wr), .data_rd(data_rd),
    .busy(busy), .done(done), .spi_clk(spi_clk), .cs(cs), .mosi(mosi), .miso(miso),
    .state(state), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Done monitor: each done pops one expected data_rd.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done with data_rd 0x%0h, expected no done", data_rd);
      end else begin
        chk("data_rd", 32'(data_rd), 32'(exp_rd_q.pop_front()));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Busy-length monitor.
  always @(negedge clk) begin
    if (!reset) busy_cnt = 0;
    else if (busy) busy_cnt++;
    else if (busy_cnt > 0) begin
      chk("busy_len", 32'(busy_cnt), 32'(BUSY_CYC));
      busy_cnt = 0;
    end
  end

  // SPI slave model driven off observed spi_clk transitions while cs is active.
  always @(negedge clk) begin
    if (!reset) begin
      s_active = 1'b0;
      prev_cs = cs;
      prev_sclk = spi_clk;
    end else begin
      if (!s_active && prev_cs == '1 && cs != '1) begin
        s_active = 1'b1;
        s_rx = '0;
        s_edges = 0;
        s_bit = 0;
        if (exp_cs_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cs: got cs 0x%0h, expected no select", cs);
        end else chk("cs_select", 32'(cs), 32'(exp_cs_q.pop_front()));
        chk("cs_fall_sclk", 32'(spi_clk), 32'(s_cpol));
        if (!s_cpha) begin
          miso_s = s_lsb ? s_word[0] : s_word[DW-1];
          s_bit = 1;
        end
      end else if (s_active && cs == '1) begin
        s_active = 1'b0;
        chk("sclk_edges", 32'(s_edges), 32'(2 * DW));
        chk("end_sclk", 32'(spi_clk), 32'(s_cpol));
        if (exp_sl_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_slave_word: got 0x%0h, expected none", s_rx);
        end else chk("slave_rx", 32'(s_rx), 32'(exp_sl_q.pop_front()));
      end else if (s_active && spi_clk != prev_sclk) begin
        s_edges++;
        s_lead = (prev_sclk == s_cpol);
        if (s_lead != s_cpha) begin
          s_rx = s_lsb ? {mosi, s_rx[DW-1:1]} : {s_rx[DW-2:0], mosi};
        end else if (s_bit < DW) begin
          miso_s = s_lsb ? s_word[s_bit] : s_word[DW-1-s_bit];
          s_bit++;
        end
      end
      prev_cs = cs;
      prev_sclk = spi_clk;
    end
  end

  task automatic launch(input logic [DW-1:0] d, input logic [CSW-1:0] sel,
                        input logic cpol, input logic cpha, input logic lsb);
    @(negedge clk);
    data_wr = d; cs_sel = sel; polarity = cpol; phase = cpha; lsb_first = lsb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble captured inputs; the transfer in flight must not notice.
    data_wr = ~d; phase = ~cpha; lsb_first = ~lsb;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic wait_cond(input string name, input logic [1:0] st, input logic [CNTW-1:0] cnt, input logic use_cnt);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (use_cnt ? (count == cnt && state == st) : (state == st)) break;
    end
    chk({name, "_state"}, 32'(state), 32'(st));
  endtask

  task automatic cfg_slave(input logic cpol, input logic cpha, input logic lsb, input logic loop,
                           input logic [DW-1:0] sw);
    s_cpol = cpol; s_cpha = cpha; s_lsb = lsb; loop_en = loop; s_word = sw;
  endtask

  task automatic run_xfer(input string name, input logic [DW-1:0] d, input logic [CSW-1:0] sel,
                          input logic cpol, input logic cpha, input logic lsb, input logic loop,
                          input logic [DW-1:0] sw, input logic [DW-1:0] exp_rd, input logic [DW-1:0] exp_sl);
    cfg_slave(cpol, cpha, lsb, loop, sw);
    exp_cs_q.push_back(~(NCS'(1) << sel));
    exp_sl_q.push_back(exp_sl);
    exp_rd_q.push_back(exp_rd);
    launch(d, sel, cpol, cpha, lsb);
    wait_done(name);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset and idle state
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cs", 32'(cs), 32'h7);
    chk("rst_sclk", 32'(spi_clk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_data_rd", 32'(data_rd), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Abort mid-transfer with reset after three bits, then a clean loopback
    cfg_slave(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    exp_cs_q.push_back(3'b101);
    launch(8'hC3, 2'd1, 1'b0, 1'b0, 1'b0);
    wait_cond("abort_wait", 2'd2, 4'd3, 1'b1);
    chk("abort_count", 32'(count), 32'd3);
    reset = 1'b0;
    #1;
    chk("abort_cs", 32'(cs), 32'h7);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sclk", 32'(spi_clk), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_data_rd", 32'(data_rd), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_done_hold", 32'(done), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort_done", 32'(done), 32'd0);
    run_xfer("fresh_c3", 8'hC3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hC3, 8'hC3);

    // Mode 0 loopback, MSB first
    run_xfer("mode0_ab", 8'hAB, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hAB, 8'hAB);

    // Modes 1..3 against slave returning 0x5C
    for (int m = 1; m < 4; m++) begin
      @(negedge clk);
      polarity = m[1];
      repeat (3) @(negedge clk);
      chk("idle_sclk_cpol", 32'(spi_clk), 32'(m[1]));
      run_xfer("mode_slave", 8'h3A, 2'd1, m[1], m[0], 1'b0, 1'b0, 8'h5C, 8'h5C, 8'h3A);
    end
    @(negedge clk);
    polarity = 1'b0;
    repeat (2) @(negedge clk);

    // LSB first: 0x01 goes out as 1 then seven 0s; slave 0x80 LSB first
    run_xfer("lsb_first", 8'h01, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 8'h01);

    // Back-to-back: start held through the done cycle
    cfg_slave(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    exp_cs_q.push_back(3'b110); exp_sl_q.push_back(8'h96); exp_rd_q.push_back(8'h96);
    exp_cs_q.push_back(3'b101); exp_sl_q.push_back(8'h69); exp_rd_q.push_back(8'h69);
    launch(8'h96, 2'd0, 1'b0, 1'b0, 1'b0);
    wait_cond("b2b_lag", 2'd3, 4'd0, 1'b0);
    data_wr = 8'h69; cs_sel = 2'd1; phase = 1'b0; lsb_first = 1'b0; start = 1'b1;
    wait_done("b2b_first");
    chk("b2b_gap_cs", 32'(cs), 32'h7);
    @(negedge clk);
    chk("b2b_second_cs", 32'(cs), 32'h5);
    chk("b2b_second_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("b2b_second");
    repeat (3) @(negedge clk);

    // Out-of-range select is dropped
    @(negedge clk);
    cs_sel = 2'd3; data_wr = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("badsel_busy", 32'(busy), 32'd0);
    chk("badsel_cs", 32'(cs), 32'h7);
    chk("badsel_state", 32'(state), 32'd0);

    // Start pulsed mid-transfer is ignored
    cfg_slave(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    exp_cs_q.push_back(3'b011); exp_sl_q.push_back(8'h5A); exp_rd_q.push_back(8'h5A);
    launch(8'h5A, 2'd2, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    cs_sel = 2'd0; data_wr = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_cs", 32'(cs), 32'h3);
    wait_done("midstart");
    repeat (12) @(negedge clk);

    chk("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    chk("slave_queue_empty", 32'(exp_sl_q.size()), 32'd0);
    chk("cs_queue_empty", 32'(exp_cs_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
